// File: rtl/rv32_pkg.sv
// Shared RV32 encoding definitions: instruction format enum, base opcodes,
// the canonical NOP, field packing and descriptor legality checks.
package rv32_pkg;

  typedef enum logic [2:0] {
    T_R  = 3'd0,
    T_I  = 3'd1,
    T_S  = 3'd2,
    T_SB = 3'd3,
    T_UJ = 3'd4,
    T_U  = 3'd5
  } inst_t;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  // Pack descriptor fields into a 32-bit word. Fields a format does not use
  // are ignored; immediates are truncated to the bits the format carries.
  function automatic logic [31:0] encode_inst(
    input logic [2:0]  typ,
    input logic [6:0]  opcode,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = RV32_NOP;
    case (typ)
      T_R:  w = {funct7, rs2, rs1, funct3, rd, opcode};
      T_I:  w = {imm[11:0], rs1, funct3, rd, opcode};
      T_S:  w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      T_SB: w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      T_U:  w = {imm[31:12], rd, opcode};
      T_UJ: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w = RV32_NOP;
    endcase
    return w;
  endfunction

  // True when imm is representable as a signed value of n bits.
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned n);
    logic [31:0] hi;
    hi = $signed(imm) >>> (n - 1);
    return (hi == '0) || (hi == '1);
  endfunction

  // Descriptor legality: immediate range/alignment per format, known type.
  function automatic logic desc_ok(input logic [2:0] typ, input logic [31:0] imm);
    logic ok;
    ok = 1'b0;
    case (typ)
      T_R:       ok = 1'b1;
      T_I, T_S:  ok = fits_signed(imm, 12);
      T_SB:      ok = fits_signed(imm, 13) && !imm[0];
      T_UJ:      ok = fits_signed(imm, 21) && !imm[0];
      T_U:       ok = (imm[11:0] == '0);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read port, occupancy count
// and a synchronous clear. DEPTH must be a power of two, >= 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clr,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_wdata,
  output logic [WIDTH-1:0]             o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_push  = i_push && !o_full && !i_clr;
  assign w_pop   = i_pop && !o_empty && !i_clr;
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  // Storage array; contents are qualified by r_count so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PTR_W.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rv32_inst_encoder.sv
// RV32 instruction encoder / program loader. Descriptors are packed into
// instruction words, queued in a FIFO and written to instruction memory
// at consecutive word addresses starting at BASE_ADDR.
// Optional build macro: RV32_ENC_CHECK_EN enables descriptor legality
// checks (illegal descriptors are consumed, dropped, and set sticky err).
module rv32_inst_encoder
  import rv32_pkg::*;
#(
  parameter int unsigned        DEPTH     = 4,
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [2:0]                  in_type,
  input  logic [6:0]                  in_opcode,
  input  logic [4:0]                  in_rd,
  input  logic [4:0]                  in_rs1,
  input  logic [4:0]                  in_rs2,
  input  logic [2:0]                  in_funct3,
  input  logic [6:0]                  in_funct7,
  input  logic [31:0]                 in_imm,
  input  logic                        mem_busy,
  output logic                        mem_wr_en,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [31:0]                 mem_wdata,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_done;
  logic               r_mem_wr_en;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [ADDR_W-1:0]  r_next_addr;

  logic [31:0]        w_enc;
  logic [31:0]        w_head;
  logic [CNT_W-1:0]   w_count;
  logic               w_empty;
  logic               w_full;
  logic               w_accept;
  logic               w_desc_ok;
  logic               w_push;
  logic               w_pop;

  assign in_ready = (r_state == S_LOAD) && !w_full;

  // A start in the same cycle restarts the session, so the concurrently
  // offered descriptor belongs to the abandoned session and is dropped.
  assign w_accept = in_valid && in_ready && !start;

  assign w_enc = encode_inst(in_type, in_opcode, in_rd, in_rs1, in_rs2,
                             in_funct3, in_funct7, in_imm);

`ifdef RV32_ENC_CHECK_EN
  logic r_err;

  assign w_desc_ok = desc_ok(in_type, in_imm);

  // Sticky error flag, cleared only by a new session or reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_err <= 1'b0;
    end else if (start) begin
      r_err <= 1'b0;
    end else if (w_accept && !w_desc_ok) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_desc_ok = 1'b1;
  assign err       = 1'b0;
`endif

  assign w_push = w_accept && w_desc_ok;
  assign w_pop  = !w_empty && !mem_busy && !start;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (n_rst),
    .i_clr   (start),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_enc),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Session control FSM with registered done flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else if (start) begin
      r_state <= S_LOAD;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept && in_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Writes are never retracted once presented, so an empty FIFO
          // means the last word is already on the memory port.
          if (w_empty) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Write stage: pop into output registers and advance the address counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_mem_wr_en <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_wdata <= '0;
      r_next_addr <= BASE_ADDR;
    end else begin
      r_mem_wr_en <= w_pop;
      if (start) begin
        r_next_addr <= BASE_ADDR;
      end else if (w_pop) begin
        r_mem_addr  <= r_next_addr;
        r_mem_wdata <= w_head;
        r_next_addr <= r_next_addr + ADDR_W'(4);
      end
    end
  end

  assign mem_wr_en = r_mem_wr_en;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign count     = w_count;
  assign done      = r_done;

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Self-checking bench for rv32_inst_encoder: directed scenarios plus a
// randomized descriptor stream against an arithmetic encoding model.
module tb_rv32_inst_encoder;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [2:0]  in_type = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        mem_busy = 1'b0;
  logic        in_ready;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  count;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  t;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } desc_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] exp_addr = BASE;
  bit          rand_busy = 1'b0;

  rv32_inst_encoder #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_type   (in_type),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .mem_busy  (mem_busy),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Extract n bits of v starting at bit lo.
  function automatic logic [31:0] bits(input logic [31:0] v, input int lo, input int n);
    return (v >> lo) & ((32'd1 << n) - 32'd1);
  endfunction

  // Reference encoding built from shifted field values.
  function automatic logic [31:0] model_enc(input desc_t d);
    logic [31:0] base_r;
    base_r = (32'(d.rs1) << 15) | (32'(d.f3) << 12) | 32'(d.opc);
    case (d.t)
      3'd0: return (32'(d.f7) << 25) | (32'(d.rs2) << 20) | base_r | (32'(d.rd) << 7);
      3'd1: return (bits(d.imm, 0, 12) << 20) | base_r | (32'(d.rd) << 7);
      3'd2: return (bits(d.imm, 5, 7) << 25) | (32'(d.rs2) << 20) | base_r
                   | (bits(d.imm, 0, 5) << 7);
      3'd3: return (bits(d.imm, 12, 1) << 31) | (bits(d.imm, 5, 6) << 25)
                   | (32'(d.rs2) << 20) | base_r | (bits(d.imm, 1, 4) << 8)
                   | (bits(d.imm, 11, 1) << 7);
      3'd4: return (bits(d.imm, 20, 1) << 31) | (bits(d.imm, 1, 10) << 21)
                   | (bits(d.imm, 11, 1) << 20) | (bits(d.imm, 12, 8) << 12)
                   | (32'(d.rd) << 7) | 32'(d.opc);
      3'd5: return (d.imm & 32'hFFFF_F000) | (32'(d.rd) << 7) | 32'(d.opc);
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic desc_t mk(input int t, input int opc, input int rd, input int rs1,
                               input int rs2, input int f3, input int f7, input logic [31:0] imm);
    desc_t d;
    d.t = 3'(t); d.opc = 7'(opc); d.rd = 5'(rd); d.rs1 = 5'(rs1);
    d.rs2 = 5'(rs2); d.f3 = 3'(f3); d.f7 = 7'(f7); d.imm = imm;
    return d;
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    d.opc = 7'($urandom); d.rd = 5'($urandom); d.rs1 = 5'($urandom);
    d.rs2 = 5'($urandom); d.f3 = 3'($urandom); d.f7 = 7'($urandom);
`ifdef RV32_ENC_CHECK_EN
    d.t = 3'($urandom_range(0, 5));
    case (d.t)
      3'd1, 3'd2: d.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      3'd3:       d.imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      3'd4:       d.imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
      3'd5:       d.imm = $urandom & 32'hFFFF_F000;
      default:    d.imm = $urandom;
    endcase
`else
    d.t = 3'($urandom_range(0, 7));
    d.imm = $urandom;
`endif
    return d;
  endfunction

  task automatic apply(input desc_t d);
    in_type = d.t; in_opcode = d.opc; in_rd = d.rd; in_rs1 = d.rs1;
    in_rs2 = d.rs2; in_funct3 = d.f3; in_funct7 = d.f7; in_imm = d.imm;
  endtask

  task automatic expect_wr(input logic [31:0] word);
    wr_t e;
    e.addr = exp_addr;
    e.data = word;
    exp_q.push_back(e);
    exp_addr = exp_addr + 32'd4;
  endtask

  // Offer one descriptor from a negedge; returns at the negedge after acceptance.
  task automatic send(input desc_t d, input bit last, input bit push, input logic [31:0] word);
    int n;
    bit rdy;
    n = 0;
    apply(d);
    in_last = last;
    in_valid = 1'b1;
    if (push) expect_wr(word);
    forever begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      @(negedge clk);
      if (rand_busy) mem_busy = ($urandom_range(0, 2) == 0);
      if (n > 500) begin
        chk("accept_timeout", 32'(rdy), 32'd1);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    if (rand_busy) mem_busy = ($urandom_range(0, 2) == 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      if (rand_busy) mem_busy = ($urandom_range(0, 2) == 0);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    mem_busy = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = BASE;
  endtask

  // Write monitor: every strobe must match the next expected write.
  always @(posedge clk) begin
    #1;
    if (mem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(mem_wr_en), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", mem_addr, mon_e.addr);
        chk("wr_data", mem_wdata, mon_e.data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    desc_t d;
    desc_t d0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);
    chk("idle_not_ready", 32'(in_ready), 32'd0);
    do_start();
    chk("load_ready", 32'(in_ready), 32'd1);

    // add x3,x1,x2 and first-write latency
    send(mk(0, 7'h33, 3, 1, 2, 0, 0, 32'd0), 1'b0, 1'b1, 32'h002081B3);
    chk("latency_k1", 32'(mem_wr_en), 32'd0);
    @(negedge clk);
    chk("latency_k2", 32'(mem_wr_en), 32'd1);
    chk("add_addr", mem_addr, BASE);
    chk("add_word", mem_wdata, 32'h002081B3);

    // beq x1,x2,-4 then jal x1,8 at following addresses
    send(mk(3, 7'h63, 0, 1, 2, 0, 0, 32'hFFFF_FFFC), 1'b0, 1'b1, 32'hFE208EE3);
    send(mk(4, 7'h6F, 1, 0, 0, 0, 0, 32'd8), 1'b0, 1'b1, 32'h008000EF);
    wait_drain();

    // Backpressure: fill FIFO while memory is busy
    do_start();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = rand_desc();
      send(d, 1'b0, 1'b1, model_enc(d));
    end
    d = rand_desc();
    apply(d);
    in_valid = 1'b1;
    expect_wr(model_enc(d));
    chk("full_not_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    mem_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("consec_wr", 32'(mem_wr_en), 32'd1);
      if (i == 1) in_valid = 1'b0;
    end
    chk("drained_count", 32'(count), 32'd0);
    wait_drain();

    // Two-descriptor session with in_last, then a refused third
    do_start();
    chk("done_cleared", 32'(done), 32'd0);
    d = rand_desc();
    send(d, 1'b0, 1'b1, model_enc(d));
    d = rand_desc();
    send(d, 1'b1, 1'b1, model_enc(d));
    chk("ready_after_last", 32'(in_ready), 32'd0);
    d = rand_desc();
    apply(d);
    in_valid = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    chk("done_during_last_wr", 32'(done), 32'd0);
    chk("last_wr_present", 32'(mem_wr_en), 32'd1);
    @(negedge clk);
    chk("done_after_last_wr", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    chk("no_accept_after_last", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_drain();

    // I-type immediate 2048 is out of signed 12-bit range
    do_start();
`ifdef RV32_ENC_CHECK_EN
    send(mk(1, 7'h13, 6, 5, 0, 0, 0, 32'd2048), 1'b1, 1'b0, 32'd0);
    wait_drain();
    chk("imm2048_err", 32'(err), 32'd1);
`else
    send(mk(1, 7'h13, 6, 5, 0, 0, 0, 32'd2048), 1'b1, 1'b1, 32'h80028313);
    wait_drain();
    chk("imm2048_err", 32'(err), 32'd0);
`endif
    chk("imm2048_done", 32'(done), 32'd1);

    // Randomized stream with random memory backpressure
    do_start();
    chk("err_cleared", 32'(err), 32'd0);
    rand_busy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d = rand_desc();
      send(d, (i == 39), 1'b1, model_enc(d));
    end
    wait_drain();
    rand_busy = 1'b0;
    mem_busy = 1'b0;
    chk("rand_done", 32'(done), 32'd1);
    chk("rand_err", 32'(err), 32'd0);

    // Reset while draining a 3-entry FIFO
    do_start();
    mem_busy = 1'b1;
    d0 = rand_desc();
    send(d0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      d = rand_desc();
      send(d, 1'b0, 1'b0, 32'd0);
    end
    chk("pre_reset_count", 32'(count), 32'd3);
    expect_wr(model_enc(d0));
    mem_busy = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_reset_wr", 32'(mem_wr_en), 32'd1);
    n_rst = 1'b0;
    #1;
    chk("reset_wr_en", 32'(mem_wr_en), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("idle_after_reset", 32'(in_ready), 32'd0);
    chk("count_after_reset", 32'(count), 32'd0);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
